serial_word_shifter: RTL and testbench
======================================

Name: serial_word_shifter

Overview:
- Parallel-in, serial-out framing stage directly upstream of the bit-serial two's-complement FSM.
- Accepts a WIDTH-bit word over a valid/ready handshake and emits it LSB-first, one bit per clk.
- Generates a one-cycle clear pulse before the first bit, so the downstream FSM starts each word in its "no 1 seen yet" state, and flags the last bit of each word.

Parameters:
- WIDTH, 8, word length in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- load_data  input  WIDTH  word to serialise; captured on handshake.
- load_valid  input  1  producer has a word on load_data.
- load_ready  output  1  shifter can accept a word this cycle.
- fsm_clr  output  1  one-cycle pulse; drives the downstream FSM reset input.
- ser_out  output  1  serial bit to the downstream FSM input, LSB first.
- ser_valid  output  1  ser_out carries a live data bit this cycle.
- last_bit  output  1  high with bit WIDTH-1 (the MSB) of the current word.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE, shift register=0, count=0.
  - While reset is low: load_ready=0, fsm_clr=0, ser_out=0, ser_valid=0, last_bit=0.
  - A word being shifted when reset is asserted is discarded; there is no partial output after reset releases.
- States: IDLE, CLR, SHIFT. All outputs are decoded from registered state only (Moore).
- IDLE:
  - load_ready=1.
  - On load_valid&&load_ready: shreg<=load_data, count<=0, next state CLR.
  - Otherwise stay in IDLE.
- CLR (exactly 1 cycle):
  - fsm_clr=1, load_ready=0, ser_valid=0.
  - Next state SHIFT unconditionally.
- SHIFT:
  - ser_out=shreg[0], ser_valid=1.
  - Each cycle: shreg<=shreg>>1 (zero fill), count<=count+1.
  - last_bit=1 when count==WIDTH-1.
  - On the last-bit cycle: load_ready=1. If load_valid is also high, capture the new word and go to CLR (back-to-back); otherwise go to IDLE.
  - load_ready=0 on all other SHIFT cycles; load_valid is ignored there.
- Latency: handshake at edge N -> fsm_clr high in cycle N+1 -> bit0 in cycle N+2 -> bit WIDTH-1 in cycle N+WIDTH+1.
- Throughput: back-to-back words take WIDTH+1 cycles each (one CLR gap).
- The counter never wraps. Exit from SHIFT occurs exactly at count==WIDTH-1, and count is reloaded to 0 on capture.
- ser_out=0 whenever ser_valid=0.
- load_data is sampled only on the handshake edge; later changes do not affect the word in flight.

Decomposition:
- Shared package coa_serial_pkg holds:
  - state localparams S_IDLE=2'd0, S_CLR=2'd1, S_SHIFT=2'd2;
  - default WIDTH constant 8.
  - The downstream serial_word_collector reuses the package.
- No sub-module: the shift register, counter and 3-state FSM form one module.
- The bench instantiates the existing two's-complement FSM as the consumer.

Test Plan:
1. Single word: WIDTH=8, load 8'h06 at cycle 0 -> fsm_clr=1 at cycle 1; ser_out 0,1,1,0,0,0,0,0 at cycles 2..9; last_bit=1 only at cycle 9; FSM output serialised = 8'hFA.
2. Back-to-back: 8'h01 then 8'h80 with load_valid held high -> second capture on the first word's last-bit cycle; one CLR cycle between words; FSM results 8'hFF and 8'h80.
3. Ignored load: load_valid pulsed with 8'h55 during CLR and mid-SHIFT -> load_ready=0, word not captured, current serial stream unchanged.
4. Reset mid-operation: reset=0 after bit 3 of 8'hF0 -> next cycle all outputs 0, state IDLE; reset=1 then load 8'h00 -> eight zero bits, FSM result 8'h00.
5. Boundary width: WIDTH=2, load 2'b10 -> bits 0,1 with last_bit on the second bit; FSM result 2'b10.
6. Post-reset idle: no load_valid for 20 cycles -> load_ready=1, ser_valid=0, fsm_clr=0 throughout.

Source files
------------

// File: rtl/coa_serial_pkg.sv
// Shared definitions for the bit-serial framing path.
// Used by serial_word_shifter (parallel-in, serial-out) and by the
// downstream serial_word_collector.
//   DEFAULT_WIDTH : default word length in bits
//   state_e       : framing FSM states (IDLE -> CLR -> SHIFT)
package coa_serial_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLR   = 2'd1,
        S_SHIFT = 2'd2
    } state_e;

endpackage

// File: rtl/serial_word_shifter.sv
// Parallel-in, serial-out framing stage feeding the bit-serial two's-complement
// FSM. A word is taken over a valid/ready handshake, a one-cycle clear pulse
// is issued to the downstream FSM, then the word is sent LSB first, one bit
// per clock, with the MSB flagged by last_bit.
//
// Handshake: a word transfers on a rising clk edge where load_valid and
// load_ready are both high. load_ready does not depend on load_valid. The
// producer holds load_data stable while load_valid is high and not yet
// accepted; load_data is sampled only on the transfer edge.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-low reset
//   load_data  in   [WIDTH-1:0] word to serialise
//   load_valid in   producer offers load_data
//   load_ready out  shifter accepts a word this cycle (IDLE or last-bit cycle)
//   fsm_clr    out  one-cycle clear pulse for the downstream FSM
//   ser_out    out  serial data bit, LSB first, 0 when not valid
//   ser_valid  out  ser_out carries a live bit
//   last_bit   out  high with bit WIDTH-1 of the current word
module serial_word_shifter
    import coa_serial_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             fsm_clr,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             last_bit
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             is_last;
    logic             accept;

    // Outputs are decoded from registered state. They are additionally
    // qualified by reset so that everything reads 0 for the whole time reset
    // is held low, not only from the first edge after it is asserted.
    assign is_last    = (state_q == S_SHIFT) && (count_q == CNT_W'(WIDTH - 1));
    assign load_ready = reset && ((state_q == S_IDLE) || is_last);
    assign fsm_clr    = reset && (state_q == S_CLR);
    assign ser_valid  = reset && (state_q == S_SHIFT);
    assign ser_out    = ser_valid && shreg_q[0];
    assign last_bit   = reset && is_last;
    assign accept     = load_valid && load_ready;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    shreg_d = load_data;
                    count_d = '0;
                    state_d = S_CLR;
                end
            end
            S_CLR: begin
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                shreg_d = shreg_q >> 1;
                count_d = count_q + 1'b1;
                if (is_last) begin
                    // Count is reloaded here so it never wraps past WIDTH-1.
                    count_d = '0;
                    if (accept) begin
                        // Back-to-back word: capture now, one CLR gap follows.
                        shreg_d = load_data;
                        state_d = S_CLR;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_serial_word_shifter.sv
// Bench for serial_word_shifter: lane 0 runs WIDTH=8, lane 1 runs WIDTH=2.
// Each lane has a cycle-exact expected-output queue filled on accepted
// handshakes, plus a model of the downstream serial two's-complement FSM
// whose per-word result is checked against -word.
module tb_serial_word_shifter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ld_data  [2];
    logic        ld_valid [2];
    logic        ld_ready [2];
    logic        clr      [2];
    logic        sout     [2];
    logic        svalid   [2];
    logic        lbit     [2];

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- lanes: DUT + scoreboard + consumer model ----------------
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        localparam int W = (gi == 0) ? 8 : 2;

        serial_word_shifter #(.WIDTH(W)) u_dut (
            .clk        (clk),
            .reset      (reset),
            .load_data  (ld_data[gi][W-1:0]),
            .load_valid (ld_valid[gi]),
            .load_ready (ld_ready[gi]),
            .fsm_clr    (clr[gi]),
            .ser_out    (sout[gi]),
            .ser_valid  (svalid[gi]),
            .last_bit   (lbit[gi])
        );

        // Expected per-cycle tuple {fsm_clr, ser_valid, ser_out, last_bit}.
        logic [3:0]  exp_q[$];
        logic [31:0] res_q[$];
        logic [31:0] acc;
        logic        seen1;
        int          bit_idx;

        always @(negedge clk) begin
            logic [3:0]  exp_o;
            logic        exp_rdy;
            logic [31:0] w;
            logic [31:0] mask;
            mask = (32'd1 << W) - 32'd1;
            if (!reset) begin
                exp_q.delete();
                res_q.delete();
                check($sformatf("l%0d_rst_out", gi), {28'd0, clr[gi], svalid[gi], sout[gi], lbit[gi]}, 32'd0);
                check($sformatf("l%0d_rst_rdy", gi), {31'd0, ld_ready[gi]}, 32'd0);
            end else begin
                exp_o   = (exp_q.size() > 0) ? exp_q.pop_front() : 4'b0000;
                exp_rdy = (exp_q.size() == 0);
                check($sformatf("l%0d_out", gi), {28'd0, clr[gi], svalid[gi], sout[gi], lbit[gi]}, {28'd0, exp_o});
                check($sformatf("l%0d_rdy", gi), {31'd0, ld_ready[gi]}, {31'd0, exp_rdy});

                // Downstream two's-complement FSM: copy bits up to and
                // including the first 1, invert the rest.
                if (clr[gi]) begin
                    acc     = 32'd0;
                    seen1   = 1'b0;
                    bit_idx = 0;
                end else if (svalid[gi]) begin
                    if (bit_idx < 32) acc[bit_idx] = seen1 ? ~sout[gi] : sout[gi];
                    seen1 = seen1 | sout[gi];
                    bit_idx++;
                    if (lbit[gi] && res_q.size() > 0)
                        check($sformatf("l%0d_neg", gi), acc, res_q.pop_front());
                end

                // Handshake edge follows this negedge: push the expected frame.
                if (ld_valid[gi] && exp_rdy) begin
                    w = ld_data[gi] & mask;
                    exp_q.push_back(4'b1000);
                    for (int i = 0; i < W; i++)
                        exp_q.push_back({1'b0, 1'b1, w[i], (i == W - 1)});
                    res_q.push_back((~w + 32'd1) & mask);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Offer a word; returns just after the transfer edge. With hold=1,
    // load_valid stays high for a following back-to-back word.
    task automatic send(input int lane, input logic [31:0] w, input bit hold);
        bit done;
        done = 1'b0;
        ld_data[lane]  = w;
        ld_valid[lane] = 1'b1;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (ld_ready[lane]) done = 1'b1;
        end
        if (!done) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (!hold || !done) ld_valid[lane] = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_valid(input int lane, input logic [31:0] w);
        ld_data[lane]  = w;
        ld_valid[lane] = 1'b1;
        @(posedge clk);
        #1;
        ld_valid[lane] = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b0;
        for (int l = 0; l < 2; l++) begin
            ld_data[l]  = 32'd0;
            ld_valid[l] = 1'b0;
        end
        idle_cycles(3);
        reset = 1'b1;

        // Post-reset idle: 20 cycles with no load_valid.
        idle_cycles(20);

        // Single word 8'h06 -> FSM result 8'hFA.
        send(0, 32'h06, 1'b0);
        idle_cycles(12);

        // Back-to-back 8'h01 then 8'h80 with valid held high.
        send(0, 32'h01, 1'b1);
        send(0, 32'h80, 1'b0);
        idle_cycles(12);

        // Ignored loads during CLR and mid-SHIFT.
        send(0, 32'h3C, 1'b0);
        pulse_valid(0, 32'h55);
        idle_cycles(2);
        pulse_valid(0, 32'h55);
        idle_cycles(10);

        // Reset after bit 3 of 8'hF0, then load 8'h00.
        send(0, 32'hF0, 1'b0);
        idle_cycles(5);
        reset = 1'b0;
        idle_cycles(2);
        reset = 1'b1;
        idle_cycles(2);
        send(0, 32'h00, 1'b0);
        idle_cycles(12);

        // WIDTH=2 lane: 2'b10, then back-to-back 2'b01, 2'b11.
        send(1, 32'h2, 1'b0);
        idle_cycles(5);
        send(1, 32'h1, 1'b1);
        send(1, 32'h3, 1'b0);
        idle_cycles(6);

        // Random words, random back-to-back, last one released.
        for (int i = 0; i < 8; i++)
            send(0, $urandom_range(0, 255), (i < 7) ? bit'($urandom_range(0, 1)) : 1'b0);
        idle_cycles(14);

        check("l0_drain", g_lane[0].exp_q.size(), 32'd0);
        check("l1_drain", g_lane[1].exp_q.size(), 32'd0);
        check("l0_res_drain", g_lane[0].res_q.size(), 32'd0);
        check("l1_res_drain", g_lane[1].res_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
